// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter in front of a single register-file write port.
// req0 (load path) normally wins; req1 is guaranteed a grant after STARVE_LIMIT consecutive losses.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [63:0] req0_data,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [63:0] req1_data,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  input  logic        rf_write_complete,
  output logic        done0,
  output logic        done1,
  output logic        busy,
  output logic        grant_id
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        grant_q, grant_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;

  logic        pick1, accept0, accept1, accept;
  logic [4:0]  win_addr;
  logic [63:0] win_data;

  // Winner selection; readys are the only combinational outputs and stay low under reset.
  always_comb begin
    pick1    = req1_valid && (!req0_valid || (starve_q == LIMIT));
    accept1  = (state_q == IDLE) && !reset && pick1;
    accept0  = (state_q == IDLE) && !reset && req0_valid && !pick1;
    accept   = accept0 || accept1;
    win_addr = accept1 ? req1_addr : req0_addr;
    win_data = accept1 ? req1_data : req0_data;
  end

  assign req0_ready = accept0;
  assign req1_ready = accept1;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    grant_d  = grant_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          grant_d = accept1;
          if (accept1) begin
            starve_d = 4'd0;
          end else if (req1_valid && (starve_q < LIMIT)) begin
            starve_d = starve_q + 4'd1;
          end
          // A write to x0 is retired immediately without touching the register file.
          if (win_addr != 5'd0) begin
            state_d = WRITE;
            waddr_d = win_addr;
            wdata_d = win_data;
          end else begin
            done0_d = accept0;
            done1_d = accept1;
          end
        end
      end
      WRITE: begin
        if (rf_write_complete) begin
          state_d = IDLE;
          waddr_d = 5'd0;
          wdata_d = 64'd0;
          done0_d = !grant_q;
          done1_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
      waddr_q  <= 5'd0;
      wdata_q  <= 64'd0;
      grant_q  <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      grant_q  <= grant_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

  assign rf_we    = (state_q == WRITE);
  assign busy     = (state_q == WRITE);
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign grant_id = grant_q;
  assign done0    = done0_q;
  assign done1    = done1_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single write, x0 write, fairness,
// payload hold during WRITE, reset mid-write and stray completes while idle.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [63:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        rf_write_complete;
  logic        done0, done1, busy, grant_id;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .req0_valid        (req0_valid),
    .req0_addr         (req0_addr),
    .req0_data         (req0_data),
    .req1_valid        (req1_valid),
    .req1_addr         (req1_addr),
    .req1_data         (req1_data),
    .req0_ready        (req0_ready),
    .req1_ready        (req1_ready),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .rf_write_complete (rf_write_complete),
    .done0             (done0),
    .done1             (done1),
    .busy              (busy),
    .grant_id          (grant_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_addr = 5'd1; req1_addr = 5'd2;
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %0b expected 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %0b expected 0", req1_ready); end
    tick(); tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0h expected 0", rf_waddr); end
    checks++; if (rf_wdata !== 64'd0) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", rf_wdata); end
    checks++; if ({done0, done1, busy, grant_id} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {done0, done1, busy, grant_id}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_req1();
    req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 64'hDEAD;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", {req0_ready, req1_ready}); end
    tick();
    req1_valid = 1'b0;
    #1;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready_pulse: got %0b expected 0", req1_ready); end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rf_write_complete = 1'b1;
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 64'hDEAD}) begin errors++; $display("FAIL single_write_c%0d: got we=%0b addr=%0h data=%0h expected we=1 addr=5 data=dead", i, rf_we, rf_waddr, rf_wdata); end
      checks++; if ({busy, grant_id, done1} !== 3'b110) begin errors++; $display("FAIL single_status_c%0d: got busy/gid/done1=%b expected 110", i, {busy, grant_id, done1}); end
      tick();
    end
    rf_write_complete = 1'b0;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== 70'd0) begin errors++; $display("FAIL single_drop: got we=%0b addr=%0h data=%0h expected all 0", rf_we, rf_waddr, rf_wdata); end
    checks++; if ({done0, done1, busy} !== 3'b010) begin errors++; $display("FAIL single_done: got done0/done1/busy=%b expected 010", {done0, done1, busy}); end
    tick();
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %0b expected 0", done1); end
  endtask

  task automatic test_zero_addr();
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 64'h1234;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL zero_ready: got %b expected 10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0;
    checks++; if ({rf_we, busy, done0, done1} !== 4'b0010) begin errors++; $display("FAIL zero_done: got we/busy/done0/done1=%b expected 0010", {rf_we, busy, done0, done1}); end
    checks++; if (rf_wdata !== 64'd0) begin errors++; $display("FAIL zero_wdata: got %0h expected 0", rf_wdata); end
    tick();
    checks++; if ({rf_we, busy, done0} !== 3'b000) begin errors++; $display("FAIL zero_after: got we/busy/done0=%b expected 000", {rf_we, busy, done0}); end
  endtask

  task automatic test_complete_idle();
    rf_write_complete = 1'b1;
    tick(); tick();
    checks++; if ({rf_we, busy, done0, done1} !== 4'b0000) begin errors++; $display("FAIL idle_complete: got we/busy/done0/done1=%b expected 0000", {rf_we, busy, done0, done1}); end
    rf_write_complete = 1'b0;
  endtask

  // Both requesters held valid with immediate completion; seq[i] is the expected i-th winner.
  task automatic run_grants(input string tag, input int n, input logic [15:0] seq);
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 64'hAAAA;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 64'hBBBB;
    rf_write_complete = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      checks++; if ({req0_ready, req1_ready} !== (seq[i] ? 2'b01 : 2'b10)) begin errors++; $display("FAIL %s_grant%0d: got ready0/1=%b expected winner %0d", tag, i, {req0_ready, req1_ready}, seq[i]); end
      if (i > 0) begin
        checks++; if ({done0, done1} !== (seq[i-1] ? 2'b01 : 2'b10)) begin errors++; $display("FAIL %s_done%0d: got done0/1=%b expected requester %0d", tag, i - 1, {done0, done1}, seq[i-1]); end
      end
      tick();
      checks++; if ({rf_we, grant_id, rf_waddr} !== {1'b1, seq[i], seq[i] ? 5'd7 : 5'd3}) begin errors++; $display("FAIL %s_write%0d: got we=%0b gid=%0b addr=%0h expected we=1 gid=%0b", tag, i, rf_we, grant_id, rf_waddr, seq[i]); end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rf_write_complete = 1'b0;
    #1;
    checks++; if ({done0, done1} !== (seq[n-1] ? 2'b01 : 2'b10)) begin errors++; $display("FAIL %s_done_last: got done0/1=%b expected requester %0d", tag, {done0, done1}, seq[n-1]); end
    tick();
  endtask

  task automatic test_fairness();
    // LIMIT=4: four req0 wins, then req1, repeating.
    run_grants("fair", 10, 16'b0000_0010_0001_0000);
  endtask

  task automatic test_hold_payload();
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 64'h1111;
    tick();
    req1_addr = 5'd10; req1_data = 64'h2222; req0_valid = 1'b1; req0_addr = 5'd4;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL hold_ready: got %b expected 00 while busy", {req0_ready, req1_ready}); end
    checks++; if ({rf_waddr, rf_wdata} !== {5'd9, 64'h1111}) begin errors++; $display("FAIL hold_c0: got addr=%0h data=%0h expected addr=9 data=1111", rf_waddr, rf_wdata); end
    tick();
    req1_data = 64'h3333;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 64'h1111}) begin errors++; $display("FAIL hold_c1: got we=%0b addr=%0h data=%0h expected we=1 addr=9 data=1111", rf_we, rf_waddr, rf_wdata); end
    rf_write_complete = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    rf_write_complete = 1'b0;
    checks++; if ({rf_we, done1, done0} !== 3'b010) begin errors++; $display("FAIL hold_done: got we/done1/done0=%b expected 010", {rf_we, done1, done0}); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    // Two req0 wins against a waiting req1 build the starvation count to 2.
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 64'hAAAA;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 64'hBBBB;
    rf_write_complete = 1'b1;
    tick(); tick();
    tick();
    rf_write_complete = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    checks++; if ({rf_we, grant_id} !== 2'b10) begin errors++; $display("FAIL rstw_pre: got we/gid=%b expected 10", {rf_we, grant_id}); end
    reset = 1'b1;
    tick();
    checks++; if ({rf_we, busy, done0, done1} !== 4'b0000) begin errors++; $display("FAIL rstw_drop: got we/busy/done0/done1=%b expected 0000", {rf_we, busy, done0, done1}); end
    reset = 1'b0;
    tick();
    checks++; if ({done0, done1, rf_we} !== 3'b000) begin errors++; $display("FAIL rstw_nodone: got done0/done1/we=%b expected 000", {done0, done1, rf_we}); end
    // A cleared count means four req0 wins again before req1.
    run_grants("rstw", 5, 16'b0000_0000_0001_0000);
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 64'd0;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 64'd0;
    rf_write_complete = 1'b0;
    test_reset();
    test_single_req1();
    test_zero_addr();
    test_complete_idle();
    test_fairness();
    test_hold_payload();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
